// File: rtl/freq_meas_pkg.sv
// Shared types and default widths for the frequency-measurement sequencer.
package freq_meas_pkg;

  localparam int unsigned CNT_W_DEF  = 34;
  localparam int unsigned GATE_W_DEF = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StWaitCalc,
    StLatch
  } meas_state_t;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter that times the preset gate; done while the count is 1.
module gate_timer #(
  parameter int unsigned GATE_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [GATE_W-1:0] load_val_i,
  output logic              done_o
);

  logic [GATE_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      // A zero length still produces a single gate cycle.
      cnt_d = (load_val_i == '0) ? GATE_W'(1) : load_val_i;
    end else if (en_i && (cnt_q > GATE_W'(1))) begin
      cnt_d = cnt_q - GATE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == GATE_W'(1));

endmodule

// File: rtl/freq_meas_ctrl.sv
// Reciprocal-counter measurement sequencer: clear, gate, wait for calc_flag,
// then latch the count pair for the readout path with valid/ack handshake.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned GATE_W      = GATE_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 54_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_continuous,
  input  logic [GATE_W-1:0] cfg_gate_len,
  input  logic              calc_flag,
  input  logic [CNT_W-1:0]  stand_cnt,
  input  logic [CNT_W-1:0]  test_cnt,
  input  logic              res_ack,
  output logic              cnt_clr,
  output logic              gate_en,
  output logic              busy,
  output logic [CNT_W-1:0]  res_stand,
  output logic [CNT_W-1:0]  res_test,
  output logic              res_valid,
  output logic              res_overrun,
  output logic              timeout_err
);

  localparam int unsigned      TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

  meas_state_t      state_d, state_q;
  logic             calc_q;
  logic [TMO_W-1:0] tmo_d, tmo_q;
  logic             valid_d, valid_q;
  logic             overrun_d, overrun_q;
  logic             timeout_d, timeout_q;
  logic [CNT_W-1:0] stand_d, stand_q;
  logic [CNT_W-1:0] test_d, test_q;
  logic             calc_rise;
  logic             tmo_hit;
  logic             timer_load;
  logic             timer_done;

  gate_timer #(
    .GATE_W (GATE_W)
  ) u_gate_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (timer_load),
    .en_i       (state_q == StGate),
    .load_val_i (cfg_gate_len),
    .done_o     (timer_done)
  );

  assign calc_rise = calc_flag & ~calc_q;

  // Held at zero outside WAIT_CALC so every wait starts from a fresh count.
  always_comb begin
    tmo_d = '0;
    if (state_q == StWaitCalc) begin
      tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q == StWaitCalc) && (tmo_d == TMO_MAX);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    stand_d   = stand_q;
    test_d    = test_q;

    if (res_ack) begin
      valid_d = 1'b0;
    end

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StClear;
            timeout_d = 1'b0;
            overrun_d = 1'b0;
          end
        end
        StClear: state_d = StGate;
        StGate: begin
          if (timer_done) state_d = StWaitCalc;
        end
        StWaitCalc: begin
          if (calc_rise) begin
            state_d = StLatch;
          end else if (tmo_hit) begin
            timeout_d = 1'b1;
            state_d   = cfg_continuous ? StClear : StIdle;
          end
        end
        StLatch: begin
          // An ack in this cycle frees the slot for the new result.
          if (!valid_q || res_ack) begin
            stand_d = stand_cnt;
            test_d  = test_cnt;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          state_d = cfg_continuous ? StClear : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign timer_load = (state_d == StClear);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      calc_q    <= 1'b0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      stand_q   <= '0;
      test_q    <= '0;
    end else begin
      state_q   <= state_d;
      calc_q    <= calc_flag;
      tmo_q     <= tmo_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      stand_q   <= stand_d;
      test_q    <= test_d;
    end
  end

  assign cnt_clr     = (state_q == StClear);
  assign gate_en     = (state_q == StGate);
  assign busy        = (state_q != StIdle);
  assign res_stand   = stand_q;
  assign res_test    = test_q;
  assign res_valid   = valid_q;
  assign res_overrun = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: cycle-numbered expectations derived
// from the measurement timing rules plus a small result-register model.
module tb_freq_meas_ctrl;

  localparam int unsigned CNT_W  = 34;
  localparam int unsigned GATE_W = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              start;
  logic              abort;
  logic              cfg_continuous;
  logic [GATE_W-1:0] cfg_gate_len;
  logic              calc_flag;
  logic [CNT_W-1:0]  stand_cnt;
  logic [CNT_W-1:0]  test_cnt;
  logic              res_ack;
  logic              cnt_clr;
  logic              gate_en;
  logic              busy;
  logic [CNT_W-1:0]  res_stand;
  logic [CNT_W-1:0]  res_test;
  logic              res_valid;
  logic              res_overrun;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] held_s, held_t;

  freq_meas_ctrl #(
    .CNT_W       (CNT_W),
    .GATE_W      (GATE_W),
    .TIMEOUT_CYC (20)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .start          (start),
    .abort          (abort),
    .cfg_continuous (cfg_continuous),
    .cfg_gate_len   (cfg_gate_len),
    .calc_flag      (calc_flag),
    .stand_cnt      (stand_cnt),
    .test_cnt       (test_cnt),
    .res_ack        (res_ack),
    .cnt_clr        (cnt_clr),
    .gate_en        (gate_en),
    .busy           (busy),
    .res_stand      (res_stand),
    .res_test       (res_test),
    .res_valid      (res_valid),
    .res_overrun    (res_overrun),
    .timeout_err    (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] rand_cnt();
    return {2'($urandom_range(0, 3)), 32'($urandom)};
  endfunction

  // Waits for the gate to open and close; returns in the first cycle after it.
  task automatic wait_gate(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !gate_en; i++) tick();
    if (!gate_en) return;
    for (int i = 0; i < 100 && gate_en; i++) tick();
    ok = !gate_en;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cnt_clr, gate_en, busy, res_valid, res_overrun, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {cnt_clr, gate_en, busy, res_valid, res_overrun, timeout_err});
    end
    checks++;
    if (res_stand !== '0) begin
      errors++;
      $display("FAIL reset_stand: got %h expected 0", res_stand);
    end
    checks++;
    if (res_test !== '0) begin
      errors++;
      $display("FAIL reset_test: got %h expected 0", res_test);
    end
    sys_rst = 1'b0;
    tick();
  endtask

  // Start at cycle 0: clear in cycle 1, gate in 2..1+N, flag edge dly cycles after close.
  task automatic test_single_shot(input string tag, input int n, input int dly,
                                  input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] t);
    int eff, k;
    bit exp_clr, exp_gate;
    eff = (n == 0) ? 1 : n;
    k = eff + 1 + dly;
    cfg_continuous = 1'b0;
    cfg_gate_len = GATE_W'(n);
    stand_cnt = s;
    test_cnt = t;
    calc_flag = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= k; c++) begin
      tick();
      start = 1'b0;
      exp_clr = (c == 1);
      exp_gate = (c >= 2) && (c <= eff + 1);
      checks++;
      if (cnt_clr !== exp_clr) begin
        errors++;
        $display("FAIL %s cnt_clr cyc %0d: got %b expected %b", tag, c, cnt_clr, exp_clr);
      end
      checks++;
      if (gate_en !== exp_gate) begin
        errors++;
        $display("FAIL %s gate_en cyc %0d: got %b expected %b", tag, c, gate_en, exp_gate);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc %0d: got %b expected 1", tag, c, busy);
      end
    end
    calc_flag = 1'b1;
    tick();
    checks++;
    if ({res_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL %s latch_cycle valid,busy: got %b expected 01", tag, {res_valid, busy});
    end
    tick();
    checks++;
    if ({res_valid, busy} !== 2'b10) begin
      errors++;
      $display("FAIL %s result valid,busy: got %b expected 10", tag, {res_valid, busy});
    end
    checks++;
    if (res_stand !== s || res_test !== t) begin
      errors++;
      $display("FAIL %s result data: got %h/%h expected %h/%h", tag, res_stand, res_test, s, t);
    end
    calc_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({cnt_clr, busy} !== 2'b00) begin
        errors++;
        $display("FAIL %s idle_after cnt_clr,busy: got %b expected 00", tag, {cnt_clr, busy});
      end
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_stand !== s) begin
      errors++;
      $display("FAIL %s ack valid/stand: got %b/%h expected 0/%h", tag, res_valid, res_stand, s);
    end
  endtask

  task automatic test_random_gates();
    for (int i = 0; i < 4; i++) begin
      test_single_shot("rand", int'($urandom_range(0, 12)), int'($urandom_range(1, 10)),
                       rand_cnt(), rand_cnt());
    end
  endtask

  task automatic test_continuous_overrun();
    logic [CNT_W-1:0] s, t, exp_s, exp_t;
    bit exp_valid, exp_ovr, ack_now, ok;
    exp_valid = 1'b0;
    exp_ovr = 1'b0;
    exp_s = '0;
    exp_t = '0;
    cfg_continuous = 1'b1;
    cfg_gate_len = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int m = 0; m < 3; m++) begin
      s = rand_cnt();
      t = rand_cnt();
      wait_gate(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cont_gate meas %0d: got no gate expected gate pulse", m);
      end
      tick();
      tick();
      stand_cnt = s;
      test_cnt = t;
      calc_flag = 1'b1;
      tick();
      calc_flag = 1'b0;
      ack_now = (m == 2);
      res_ack = ack_now;
      if (m == 2) cfg_continuous = 1'b0;
      if (!exp_valid || ack_now) begin
        exp_s = s;
        exp_t = t;
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
      tick();
      res_ack = 1'b0;
      checks++;
      if ({res_valid, res_overrun} !== {exp_valid, exp_ovr}) begin
        errors++;
        $display("FAIL cont_flags meas %0d: got %b expected %b", m, {res_valid, res_overrun},
                 {exp_valid, exp_ovr});
      end
      checks++;
      if (res_stand !== exp_s || res_test !== exp_t) begin
        errors++;
        $display("FAIL cont_data meas %0d: got %h/%h expected %h/%h", m, res_stand, res_test,
                 exp_s, exp_t);
      end
      checks++;
      if ({cnt_clr, busy} !== {2{m < 2}}) begin
        errors++;
        $display("FAIL cont_rearm meas %0d: got %b expected %b", m, {cnt_clr, busy}, {2{m < 2}});
      end
    end
    held_s = exp_s;
    held_t = exp_t;
  endtask

  task automatic test_abort();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({busy, res_overrun} !== 2'b01) begin
      errors++;
      $display("FAIL start_abort busy,overrun: got %b expected 01", {busy, res_overrun});
    end
    cfg_gate_len = 10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({gate_en, busy, res_valid} !== 3'b001) begin
      errors++;
      $display("FAIL abort gate,busy,valid: got %b expected 001", {gate_en, busy, res_valid});
    end
    checks++;
    if (res_stand !== held_s || res_test !== held_t) begin
      errors++;
      $display("FAIL abort data: got %h/%h expected %h/%h", res_stand, res_test, held_s, held_t);
    end
    stand_cnt = ~held_s;
    calc_flag = 1'b1;
    tick();
    calc_flag = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({busy, res_valid} !== 2'b01 || res_stand !== held_s) begin
      errors++;
      $display("FAIL abort_calc_ignored busy,valid/stand: got %b/%h expected 01/%h",
               {busy, res_valid}, res_stand, held_s);
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    cfg_continuous = 1'b0;
    calc_flag = 1'b0;
    cfg_gate_len = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_gate(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_gate: got no gate expected gate pulse");
    end
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_early err,busy at +19: got %b expected 01", {timeout_err, busy});
    end
    tick();
    checks++;
    if ({timeout_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_fire err,busy at +20: got %b expected 10", {timeout_err, busy});
    end
    tick();
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: got %b expected 1", timeout_err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({timeout_err, cnt_clr} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_clear err,cnt_clr: got %b expected 01", {timeout_err, cnt_clr});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_start_busy();
    bit exp_clr, exp_gate;
    cfg_gate_len = 6;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_clr = (c == 1);
      exp_gate = (c >= 2) && (c <= 7);
      checks++;
      if ({cnt_clr, gate_en, busy} !== {exp_clr, exp_gate, 1'b1}) begin
        errors++;
        $display("FAIL busy_start cyc %0d clr,gate,busy: got %b expected %b", c,
                 {cnt_clr, gate_en, busy}, {exp_clr, exp_gate, 1'b1});
      end
      start = (c == 3);
      if (c == 3) cfg_gate_len = 2;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_calc_high();
    bit ok;
    logic [CNT_W-1:0] s, t;
    s = rand_cnt();
    t = rand_cnt();
    stand_cnt = s;
    test_cnt = t;
    calc_flag = 1'b1;
    cfg_gate_len = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_gate(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL high_gate: got no gate expected gate pulse");
    end
    tick();
    tick();
    tick();
    checks++;
    if ({busy, res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL high_no_latch busy,valid: got %b expected 10", {busy, res_valid});
    end
    calc_flag = 1'b0;
    tick();
    calc_flag = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL high_latch_cycle valid: got %b expected 0", res_valid);
    end
    tick();
    checks++;
    if ({busy, res_valid} !== 2'b01 || res_stand !== s || res_test !== t) begin
      errors++;
      $display("FAIL high_result busy,valid/data: got %b/%h/%h expected 01/%h/%h",
               {busy, res_valid}, res_stand, res_test, s, t);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    calc_flag = 1'b0;
    cfg_gate_len = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_gate(ok);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wait ok,busy: got %b%b expected 11", ok, busy);
    end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    checks++;
    if ({cnt_clr, gate_en, busy, res_valid, res_overrun, timeout_err} !== 6'b0 ||
        res_stand !== '0 || res_test !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b/%h/%h expected 000000/0/0",
               {cnt_clr, gate_en, busy, res_valid, res_overrun, timeout_err}, res_stand,
               res_test);
    end
    calc_flag = 1'b1;
    tick();
    calc_flag = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_lost busy,valid: got %b expected 00", {busy, res_valid});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_continuous = 1'b0;
    cfg_gate_len = '0;
    calc_flag = 1'b0;
    stand_cnt = '0;
    test_cnt = '0;
    res_ack = 1'b0;
    test_reset();
    test_single_shot("single", 10, 5, 34'h2_0000_0001, 34'h0_0001_2345);
    test_single_shot("gate0", 0, 2, 34'h1_2345_6789, 34'h3_0000_0000);
    test_random_gates();
    test_continuous_overrun();
    test_abort();
    test_timeout();
    test_start_busy();
    test_calc_high();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
